// File: rtl/carus_sram_port_arbiter.sv
// carus_sram_port_arbiter: round-robin arbiter of NUM_PORTS OBI-style requesters onto one SRAM bank port
//
// Purpose: picks one requester per cycle (first asserted req_i at or after r_prio, wrapping),
//          muxes its command onto the sram_* port and returns a per-port rvalid/rdata response.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_i/we_i                    per-port request / write enable
//   addr_i/wdata_i/be_i           per-port word address, write data, byte enables (packed, port 0 lowest)
//   gnt_o                         per-port combinational grant, one-hot or zero
//   rvalid_o/rdata_o              per-port response; rdata is zero for writes and idle ports
//   sram_req_o..sram_be_o         command to the bank wrapper
//   sram_rdata_i                  bank read data, valid one cycle after a read request
// Configuration: define CARUS_SRAM_ARB_RDATA_REG_EN to register sram_rdata_i before rdata_o
//                (response latency 2 instead of 1; still one accept per cycle).
module carus_sram_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_WORDS  = 1024,
    parameter int DATA_WIDTH = 32,
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BW = DATA_WIDTH / 8,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*AW-1:0]         addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_PORTS*BW-1:0]         be_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [AW-1:0]                   sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_wdata_o,
    output logic [BW-1:0]                   sram_be_o,
    input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);
    logic [PW-1:0]         r_prio;
    logic [PW-1:0]         r_resp_port;
    logic                  r_resp_valid;
    logic                  r_resp_we;
    logic                  w_found;
    logic [PW-1:0]         w_gnt_idx;
    logic [PW-1:0]         w_cand;
    logic [PW:0]           w_sum;
    logic [PW-1:0]         w_next_prio;
    logic                  w_out_valid;
    logic [PW-1:0]         w_out_port;
    logic [DATA_WIDTH-1:0] w_out_data;

    // Scan from r_prio upward with wrap; the sum is one bit wider so the wrap is a single subtract.
    // Grants are suppressed while reset is held so nothing reaches the bank.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum  = {1'b0, r_prio} + (PW+1)'(k);
            w_cand = PW'((w_sum >= (PW+1)'(NUM_PORTS)) ? w_sum - (PW+1)'(NUM_PORTS) : w_sum);
            if (!w_found && req_i[w_cand] && !rst_i) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign gnt_o        = w_found ? (NUM_PORTS'(1) << w_gnt_idx) : '0;
    assign sram_req_o   = w_found;
    assign sram_we_o    = w_found & we_i[w_gnt_idx];
    assign sram_addr_o  = w_found ? addr_i[w_gnt_idx*AW +: AW] : '0;
    assign sram_wdata_o = w_found ? wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign sram_be_o    = w_found ? be_i[w_gnt_idx*BW +: BW] : '0;
    assign w_next_prio  = (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_port  <= '0;
            r_resp_we    <= 1'b0;
        end else begin
            if (w_found)
                r_prio <= w_next_prio;
            r_resp_valid <= w_found;
            r_resp_port  <= w_gnt_idx;
            r_resp_we    <= sram_we_o;
        end
    end

`ifdef CARUS_SRAM_ARB_RDATA_REG_EN
    logic                  r_out_valid;
    logic [PW-1:0]         r_out_port;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Second pipeline entry; write responses capture zero so rdata_o needs no extra gating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
            r_rdata     <= '0;
        end else begin
            r_out_valid <= r_resp_valid;
            r_out_port  <= r_resp_port;
            r_rdata     <= (r_resp_valid && !r_resp_we) ? sram_rdata_i : '0;
        end
    end

    assign w_out_valid = r_out_valid;
    assign w_out_port  = r_out_port;
    assign w_out_data  = r_rdata;
`else
    assign w_out_valid = r_resp_valid;
    assign w_out_port  = r_resp_port;
    assign w_out_data  = r_resp_we ? '0 : sram_rdata_i;
`endif

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (w_out_valid) begin
            rvalid_o[w_out_port]                             = 1'b1;
            rdata_o[w_out_port*DATA_WIDTH +: DATA_WIDTH] = w_out_data;
        end
    end
endmodule
